// File: rtl/bram_req_ctrl.sv
// Valid/ready request front end for a single-port BRAM with 1-cycle registered read and 2-entry response buffer.
// Optional power-up array clear is built when BRAM_CTRL_CLEAR_EN is defined.
module bram_req_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    logic                  clearing;
    logic                  run;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CTRL_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    state_t                state_p0, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr_p0, clr_addr_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p0    <= ST_CLEAR;
            clr_addr_p0 <= '0;
        end else begin
            state_p0    <= state_nxt;
            clr_addr_p0 <= clr_addr_nxt;
        end
    end

    // Counter wraps back to 0 on the same edge that leaves CLEAR.
    always_comb begin
        state_nxt    = state_p0;
        clr_addr_nxt = clr_addr_p0;
        if (state_p0 == ST_CLEAR) begin
            clr_addr_nxt = clr_addr_p0 + ADDR_WIDTH'(1);
            if (&clr_addr_p0)
                state_nxt = ST_RUN;
        end
    end

    assign clearing = (state_p0 == ST_CLEAR);
    assign run      = reset_n & (state_p0 == ST_RUN);
    assign busy     = clearing;
    assign clr_addr = clr_addr_p0;
`else
    assign clearing = 1'b0;
    assign run      = reset_n;
    assign busy     = 1'b0;
    assign clr_addr = '0;
`endif

    // ---- stage 0: request issue ----
    logic       vld_p1;
    logic [1:0] cnt_p2;
    logic       wr_ptr_p2, rd_ptr_p2;
    logic       pop, credit_ok, req_fire, rd_fire;

    assign pop       = rsp_valid & rsp_ready;
    assign credit_ok = (cnt_p2 == 2'd0) | ((cnt_p2 == 2'd1) & ~vld_p1);
    assign req_ready = run & (credit_ok | pop);
    assign req_fire  = req_valid & req_ready;
    assign rd_fire   = req_fire & ~req_we;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (reset_n & clearing) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
        end else if (run) begin
            mem_we   = req_fire & req_we;
            mem_addr = req_addr;
            mem_din  = req_wdata;
        end
    end

    // ---- stage 1: BRAM read in flight ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_fire;
    end

    // ---- stage 2: response buffer ----
    logic [DATA_WIDTH-1:0] buf_p2 [2];

    always_ff @(posedge clk) begin
        if (vld_p1)
            buf_p2[wr_ptr_p2] <= mem_dout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p2    <= 2'd0;
            wr_ptr_p2 <= 1'b0;
            rd_ptr_p2 <= 1'b0;
        end else begin
            if (vld_p1)
                wr_ptr_p2 <= ~wr_ptr_p2;
            if (pop)
                rd_ptr_p2 <= ~rd_ptr_p2;
            case ({vld_p1, pop})
                2'b10:   cnt_p2 <= cnt_p2 + 2'd1;
                2'b01:   cnt_p2 <= cnt_p2 - 2'd1;
                default: cnt_p2 <= cnt_p2;
            endcase
        end
    end

    assign rsp_valid = (cnt_p2 != 2'd0);
    assign rsp_rdata = rsp_valid ? buf_p2[rd_ptr_p2] : '0;

endmodule
